// File: rtl/ofifo_drain_arb_pkg.sv
// Shared types and default sizing for the corelet OFIFO drain arbiter.
package ofifo_drain_arb_pkg;

    localparam int COL_DEF     = 8;
    localparam int ADDR_BW_DEF = 11;
    localparam int CNT_BW_DEF  = 8;
    localparam int BASE2_DEF   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    typedef enum logic {
        CORE1 = 1'b0,
        CORE2 = 1'b1
    } core_t;

endpackage

// File: rtl/ofifo_drain_arb_rr_arb2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is core 1, req[1]/gnt[1] is core 2.
module ofifo_drain_arb_rr_arb2
    import ofifo_drain_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    core_t prio;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = (prio == CORE2) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Priority always moves to the core that was not just served.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= CORE1;
        end else if (gnt[0]) begin
            prio <= CORE2;
        end else if (gnt[1]) begin
            prio <= CORE1;
        end
    end

endmodule

// File: rtl/ofifo_drain_arb.sv
// Drains both corelet OFIFOs into the shared psum SRAM write port, one row per cycle.
// Optional DRAIN_BACKPRESSURE_EN adds psum_ready to stall grants and hold the pending write.
module ofifo_drain_arb
    import ofifo_drain_arb_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int addr_bw = ADDR_BW_DEF,
    parameter int cnt_bw  = CNT_BW_DEF,
    parameter int BASE2   = BASE2_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cnt_bw-1:0]  num_rows,
    input  logic               ofifo_valid,
    input  logic               ofifo_valid2,
`ifdef DRAIN_BACKPRESSURE_EN
    input  logic               psum_ready,
`endif
    output logic               ofifo_rd,
    output logic               ofifo2_rd,
    output logic               psum_wen,
    output logic [addr_bw-1:0] psum_addr,
    output logic               psum_sel,
    output logic               busy,
    output logic               done
);

    if (col < 1) begin : g_col_check
        $error("ofifo_drain_arb: col must be positive");
    end

    drain_state_t      state;
    logic [cnt_bw-1:0] num_rows_q;
    logic [cnt_bw-1:0] cnt1;
    logic [cnt_bw-1:0] cnt2;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              write_ready;
    logic              arb_en;
    logic              rd_any;
    logic              leave_drain;

`ifdef DRAIN_BACKPRESSURE_EN
    assign write_ready = psum_ready;
`else
    assign write_ready = 1'b1;
`endif

    // A core that has already delivered its rows is never requested again.
    assign req[0] = ofifo_valid  && (cnt1 < num_rows_q);
    assign req[1] = ofifo_valid2 && (cnt2 < num_rows_q);
    assign arb_en = (state == DRAIN) && write_ready;

    ofifo_drain_arb_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign ofifo_rd  = gnt[0];
    assign ofifo2_rd = gnt[1];
    assign rd_any    = |gnt;

    assign leave_drain = (state == DRAIN) && (cnt1 == num_rows_q) && (cnt2 == num_rows_q)
                         && !rd_any && (!psum_wen || write_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            num_rows_q <= '0;
            cnt1       <= '0;
            cnt2       <= '0;
            psum_wen   <= 1'b0;
            psum_addr  <= '0;
            psum_sel   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Address uses the row index before the counter advances.
            if (write_ready) begin
                psum_wen <= rd_any;
                if (gnt[0]) begin
                    psum_sel  <= 1'b0;
                    psum_addr <= addr_bw'(cnt1);
                end else if (gnt[1]) begin
                    psum_sel  <= 1'b1;
                    psum_addr <= addr_bw'(BASE2) + addr_bw'(cnt2);
                end
            end

            if (gnt[0]) begin
                cnt1 <= cnt1 + cnt_bw'(1);
            end
            if (gnt[1]) begin
                cnt2 <= cnt2 + cnt_bw'(1);
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_rows_q <= num_rows;
                        cnt1       <= '0;
                        cnt2       <= '0;
                        busy       <= 1'b1;
                        state      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (leave_drain) begin
                        done  <= 1'b1;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ofifo_drain_arb.sv
// Self-checking bench for ofifo_drain_arb: directed vector table, hand sequences, randomized run vs reference model.
module tb_ofifo_drain_arb;

    localparam int BASE2 = 64;

    typedef struct {
        bit rd1;
        bit rd2;
        bit wen;
        int addr;
        bit sel;
        bit busy;
        bit done;
    } exp_t;

    typedef struct {
        bit   rst;
        bit   st;
        int   n;
        bit   v1;
        bit   v2;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_rows;
    logic        ofifo_valid;
    logic        ofifo_valid2;
    logic        psum_ready;
    logic        ofifo_rd;
    logic        ofifo2_rd;
    logic        psum_wen;
    logic [10:0] psum_addr;
    logic        psum_sel;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0 idle, 1 draining, 2 flushing.
    int m_phase, m_n, m_c1, m_c2, m_addr;
    bit m_tie2, m_wen, m_sel, m_busy, m_done;

    // Order-independent scoreboard of accepted writes per drain.
    int sb_n, sb_next1, sb_next2;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ofifo_drain_arb #(.col(8), .addr_bw(11), .cnt_bw(8), .BASE2(BASE2)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_rows     (num_rows),
        .ofifo_valid  (ofifo_valid),
        .ofifo_valid2 (ofifo_valid2),
`ifdef DRAIN_BACKPRESSURE_EN
        .psum_ready   (psum_ready),
`endif
        .ofifo_rd     (ofifo_rd),
        .ofifo2_rd    (ofifo2_rd),
        .psum_wen     (psum_wen),
        .psum_addr    (psum_addr),
        .psum_sel     (psum_sel),
        .busy         (busy),
        .done         (done)
    );

    function automatic vec_t mkv(bit rst, bit st, int n, bit v1, bit v2,
                                 bit rd1, bit rd2, bit wen, int addr, bit sel, bit bsy, bit dn);
        vec_t v;
        v.rst = rst; v.st = st; v.n = n; v.v1 = v1; v.v2 = v2;
        v.e.rd1 = rd1; v.e.rd2 = rd2; v.e.wen = wen; v.e.addr = addr;
        v.e.sel = sel; v.e.busy = bsy; v.e.done = dn;
        return v;
    endfunction

    task automatic applyStimulus(input bit rst, input bit st, input int n,
                                 input bit v1, input bit v2, input bit rdy);
        @(negedge clk);
        reset        = rst;
        start        = st;
        num_rows     = 8'(n);
        ofifo_valid  = v1;
        ofifo_valid2 = v2;
        psum_ready   = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input exp_t e);
        checkOutput({tag, "_rd1"}, 32'(ofifo_rd), 32'(e.rd1));
        checkOutput({tag, "_rd2"}, 32'(ofifo2_rd), 32'(e.rd2));
        checkOutput({tag, "_wen"}, 32'(psum_wen), 32'(e.wen));
        if (e.wen) begin
            checkOutput({tag, "_addr"}, 32'(psum_addr), 32'(e.addr));
            checkOutput({tag, "_sel"}, 32'(psum_sel), 32'(e.sel));
        end
        checkOutput({tag, "_busy"}, 32'(busy), 32'(e.busy));
        checkOutput({tag, "_done"}, 32'(done), 32'(e.done));
    endtask

    function automatic void modelGrant(output bit g1, output bit g2);
        bit e1, e2;
        g1 = 1'b0;
        g2 = 1'b0;
        if (m_phase != 1 || psum_ready !== 1'b1) return;
        e1 = (ofifo_valid === 1'b1) && (m_c1 < m_n);
        e2 = (ofifo_valid2 === 1'b1) && (m_c2 < m_n);
        if (e1 && e2) begin
            g2 = m_tie2;
            g1 = !m_tie2;
        end else begin
            g1 = e1;
            g2 = e2;
        end
    endfunction

    function automatic exp_t modelExpect();
        exp_t e;
        bit g1, g2;
        modelGrant(g1, g2);
        e.rd1 = g1; e.rd2 = g2; e.wen = m_wen; e.addr = m_addr;
        e.sel = m_sel; e.busy = m_busy; e.done = m_done;
        return e;
    endfunction

    function automatic void modelStep();
        bit g1, g2, pend, leave;
        modelGrant(g1, g2);
        if (reset === 1'b1) begin
            m_phase = 0; m_n = 0; m_c1 = 0; m_c2 = 0; m_addr = 0;
            m_tie2 = 0; m_wen = 0; m_sel = 0; m_busy = 0; m_done = 0;
            sb_n = 0; sb_next1 = 0; sb_next2 = 0;
            return;
        end
        pend  = m_wen && (psum_ready !== 1'b1);
        leave = (m_phase == 1) && (m_c1 == m_n) && (m_c2 == m_n) && !g1 && !g2 && !pend;
        if (psum_ready === 1'b1) begin
            m_wen = g1 || g2;
            if (g1) begin m_sel = 1'b0; m_addr = m_c1; end
            if (g2) begin m_sel = 1'b1; m_addr = BASE2 + m_c2; end
        end
        if (g1) begin m_c1++; m_tie2 = 1'b1; end
        if (g2) begin m_c2++; m_tie2 = 1'b0; end
        m_done = 1'b0;
        case (m_phase)
            0: if (start === 1'b1) begin
                   m_n = int'(num_rows); m_c1 = 0; m_c2 = 0; m_phase = 1; m_busy = 1'b1;
                   sb_n = int'(num_rows); sb_next1 = 0; sb_next2 = 0;
               end
            1: if (leave) begin m_phase = 2; m_done = 1'b1; end
            default: begin m_phase = 0; m_busy = 1'b0; end
        endcase
    endfunction

    task automatic scoreObserve(input string tag);
        if (psum_wen === 1'b1 && psum_ready === 1'b1) begin
            if (psum_sel === 1'b0) begin
                checkOutput({tag, "_sb_addr1"}, 32'(psum_addr), 32'(sb_next1));
                sb_next1++;
            end else begin
                checkOutput({tag, "_sb_addr2"}, 32'(psum_addr), 32'(BASE2 + sb_next2));
                sb_next2++;
            end
        end
        if (done === 1'b1) begin
            checkOutput({tag, "_sb_rows1"}, 32'(sb_next1), 32'(sb_n));
            checkOutput({tag, "_sb_rows2"}, 32'(sb_next2), 32'(sb_n));
        end
    endtask

    task automatic runCycle(input string tag, input bit rst, input bit st, input int n,
                            input bit v1, input bit v2, input bit rdy);
        exp_t e;
        applyStimulus(rst, st, n, v1, v2, rdy);
        e = modelExpect();
        checkAll(tag, e);
        scoreObserve(tag);
        modelStep();
    endtask

    initial begin
        bit rst, st, v1, v2, rdy;
        int n;

        // Two reset cycles: everything idle and zero.
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mkv(1,0,0,0,0, 0,0,0,0,0,0,0));
        // num_rows=3, both cores valid: grants alternate, addrs 0,64,1,65,2,66.
        tbl.push_back(mkv(0,1,3,1,1, 0,0,0, 0,0,0,0));
        tbl.push_back(mkv(0,0,3,1,1, 1,0,0, 0,0,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 0,1,1, 0,0,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 1,0,1,64,1,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 0,1,1, 1,0,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 1,0,1,65,1,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 0,1,1, 2,0,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 0,0,1,66,1,1,0));
        tbl.push_back(mkv(0,0,3,1,1, 0,0,0, 0,0,1,1));
        tbl.push_back(mkv(0,0,3,0,0, 0,0,0, 0,0,0,0));
        // num_rows=4: core 2 delivers first, then core 1 alone for 4 consecutive reads.
        tbl.push_back(mkv(0,1,4,0,0, 0,0,0, 0,0,0,0));
        tbl.push_back(mkv(0,0,4,0,1, 0,1,0, 0,0,1,0));
        tbl.push_back(mkv(0,0,4,0,1, 0,1,1,64,1,1,0));
        tbl.push_back(mkv(0,0,4,0,1, 0,1,1,65,1,1,0));
        tbl.push_back(mkv(0,0,4,0,1, 0,1,1,66,1,1,0));
        tbl.push_back(mkv(0,0,4,1,0, 1,0,1,67,1,1,0));
        tbl.push_back(mkv(0,0,4,1,0, 1,0,1, 0,0,1,0));
        tbl.push_back(mkv(0,0,4,1,0, 1,0,1, 1,0,1,0));
        tbl.push_back(mkv(0,0,4,1,0, 1,0,1, 2,0,1,0));
        tbl.push_back(mkv(0,0,4,1,0, 0,0,1, 3,0,1,0));
        tbl.push_back(mkv(0,0,4,1,0, 0,0,0, 0,0,1,1));
        tbl.push_back(mkv(0,0,4,1,0, 0,0,0, 0,0,0,0));
        // num_rows=0: no reads or writes, done two cycles after start.
        tbl.push_back(mkv(0,1,0,1,1, 0,0,0, 0,0,0,0));
        tbl.push_back(mkv(0,0,0,1,1, 0,0,0, 0,0,1,0));
        tbl.push_back(mkv(0,0,0,1,1, 0,0,0, 0,0,1,1));
        tbl.push_back(mkv(0,0,0,0,0, 0,0,0, 0,0,0,0));

        m_phase = 0; m_n = 0; m_c1 = 0; m_c2 = 0; m_addr = 0;
        m_tie2 = 0; m_wen = 0; m_sel = 0; m_busy = 0; m_done = 0;
        sb_n = 0; sb_next1 = 0; sb_next2 = 0;

        reset = 1'b1; start = 1'b0; num_rows = '0;
        ofifo_valid = 1'b0; ofifo_valid2 = 1'b0; psum_ready = 1'b1;
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("tbl%0d", i);
            applyStimulus(tbl[i].rst, tbl[i].st, tbl[i].n, tbl[i].v1, tbl[i].v2, 1'b1);
            checkAll(tag, tbl[i].e);
            scoreObserve(tag);
            modelStep();
        end

        // Reset after two of four rows aborts the drain with no done.
        runCycle("rstmid", 0, 1, 4, 1, 0, 1);
        runCycle("rstmid", 0, 0, 4, 1, 0, 1);
        runCycle("rstmid", 0, 0, 4, 1, 0, 1);
        runCycle("rstmid", 1, 0, 4, 0, 0, 1);
        applyStimulus(0, 0, 4, 1, 1, 1);
        checkOutput("rstmid_after_rd1", 32'(ofifo_rd), 32'd0);
        checkOutput("rstmid_after_wen", 32'(psum_wen), 32'd0);
        checkOutput("rstmid_after_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_after_done", 32'(done), 32'd0);
        scoreObserve("rstmid_after");
        modelStep();

        // Fresh start restarts at addr 0; a second start while busy is ignored.
        runCycle("restart", 0, 1, 4, 1, 1, 1);
        runCycle("restart", 0, 0, 4, 1, 1, 1);
        applyStimulus(0, 0, 4, 1, 1, 1);
        checkOutput("restart_first_addr", 32'(psum_addr), 32'd0);
        checkAll("restart", modelExpect());
        scoreObserve("restart");
        modelStep();
        runCycle("busystart", 0, 1, 2, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            runCycle("restart", 0, 0, 4, 1, 1, 1);
        end

`ifdef DRAIN_BACKPRESSURE_EN
        // psum_ready low for 3 cycles mid-drain: no reads, pending write held.
        runCycle("bp", 1, 0, 0, 0, 0, 1);
        runCycle("bp", 0, 1, 4, 1, 1, 1);
        for (int i = 0; i < 3; i++) runCycle("bp", 0, 0, 4, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            runCycle("bp_stall", 0, 0, 4, 1, 1, 0);
            checkOutput("bp_stall_no_rd", 32'(ofifo_rd | ofifo2_rd), 32'd0);
            checkOutput("bp_stall_wen_held", 32'(psum_wen), 32'd1);
        end
        for (int i = 0; i < 12; i++) runCycle("bp", 0, 0, 4, 1, 1, 1);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 9) == 0);
            n   = $urandom_range(0, 6);
            v1  = ($urandom_range(0, 3) != 0);
            v2  = ($urandom_range(0, 3) != 0);
            rdy = 1'b1;
`ifdef DRAIN_BACKPRESSURE_EN
            rdy = ($urandom_range(0, 3) != 0);
`endif
            runCycle("rand", rst, st, n, v1, v2, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
